// File: rtl/unary_add_pkg.sv
// unary_add_pkg: shared phase enum and width helpers for the unary adder
package unary_add_pkg;
  typedef enum logic {ACC = 1'b0, EMIT = 1'b1} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int pc_w(input int n);
    return clog2(n + 1);
  endfunction
endpackage

// File: rtl/unary_popcount.sv
// unary_popcount: combinational count of set bits across the unary input channels
module unary_popcount
  import unary_add_pkg::*;
#(
  parameter int NUM_IN = 4,
  localparam int PC_W = pc_w(NUM_IN)
) (
  input  logic [NUM_IN-1:0] din,
  output logic [PC_W-1:0]   pc
);
  always_comb begin
    pc = '0;
    for (int i = 0; i < NUM_IN; i++) pc = pc + PC_W'(din[i]);
  end
endmodule

// File: rtl/unary_add_n.sv
// unary_add_n: sums NUM_IN unary streams into a count, then replays it as a pulse train.
// Define UNARY_ADD_N_SAT_EN to saturate the count at its maximum instead of wrapping.
module unary_add_n
  import unary_add_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int CNT_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              read_or_write,
  input  logic [NUM_IN-1:0] din,
  output logic              dout,
  output logic              C,
  output logic              done,
  output logic [CNT_W-1:0]  level
);
  localparam int PC_W = pc_w(NUM_IN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  state_t state;
  logic [PC_W-1:0] pc;
  logic [CNT_W:0] sum;
  logic [CNT_W-1:0] acc_next;
  logic ovf;
  logic unused_state;
  unary_popcount #(.NUM_IN(NUM_IN)) u_pc (.din(din), .pc(pc));
  assign sum = {1'b0, level} + (CNT_W+1)'(pc);
  assign ovf = sum[CNT_W];
  // Phase is tracked for observability only; the datapath follows read_or_write directly.
  assign unused_state = state;
`ifdef UNARY_ADD_N_SAT_EN
  assign acc_next = ovf ? CNT_MAX : sum[CNT_W-1:0];
`else
  assign acc_next = sum[CNT_W-1:0];
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
      dout  <= 1'b0;
      C     <= 1'b0;
      done  <= 1'b0;
      state <= ACC;
    end else if (!en) begin
      dout <= 1'b0;
      C    <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= read_or_write ? EMIT : ACC;
      C     <= !read_or_write && ovf;
      dout  <= read_or_write && level != '0;
      done  <= read_or_write && level == CNT_W'(1);
      if (!read_or_write) level <= acc_next;
      else if (level != '0) level <= level - CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_unary_add_n.sv
// tb_unary_add_n: directed and random checks of unary_add_n against an integer model
module tb_unary_add_n;
  localparam int NI = 4;
  localparam int CW = 4;
  localparam int CMAX = 15;
  logic clk = 0, rst = 1, en = 0, read_or_write = 0;
  logic [NI-1:0] din = '0;
  logic dout, C, done;
  logic [CW-1:0] level;
  int errs = 0, checks = 0;
  int m_cnt = 0;
  logic m_dout = 0, m_c = 0, m_done = 0;
  unary_add_n #(.NUM_IN(NI), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .read_or_write(read_or_write),
    .din(din), .dout(dout), .C(C), .done(done), .level(level)
  );
  always #5 clk = ~clk;
  task automatic tick(input logic r, input logic e, input logic rw, input logic [NI-1:0] d);
    int s;
    rst = r; en = e; read_or_write = rw; din = d;
    @(posedge clk); #1;
    if (r) begin
      m_cnt = 0; m_dout = 0; m_c = 0; m_done = 0;
    end else if (!e) begin
      m_dout = 0; m_c = 0; m_done = 0;
    end else if (!rw) begin
      s = m_cnt + $countones(d);
      m_c = s > CMAX;
`ifdef UNARY_ADD_N_SAT_EN
      m_cnt = s > CMAX ? CMAX : s;
`else
      m_cnt = s % (CMAX + 1);
`endif
      m_dout = 0; m_done = 0;
    end else begin
      m_c = 0;
      m_dout = m_cnt > 0;
      m_done = m_cnt == 1;
      if (m_cnt > 0) m_cnt--;
    end
  endtask
  task automatic test_reset();
    repeat (2) tick(1, 1'($urandom), 1'($urandom), 4'($urandom));
    checks++; if (level !== 4'd0) begin errs++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (dout !== 1'b0) begin errs++; $display("FAIL reset_dout got=%b exp=0", dout); end
    checks++; if (C !== 1'b0) begin errs++; $display("FAIL reset_C got=%b exp=0", C); end
    checks++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done got=%b exp=0", done); end
  endtask
  task automatic test_accum_emit();
    int pulses = 0;
    repeat (3) tick(0, 1, 0, 4'b1011);
    checks++; if (level !== 4'd9) begin errs++; $display("FAIL acc_level got=%0d exp=9", level); end
    checks++; if (C !== 1'b0) begin errs++; $display("FAIL acc_C got=%b exp=0", C); end
    for (int k = 1; k <= 10; k++) begin
      tick(0, 1, 1, '0);
      pulses += dout;
      checks++; if (dout !== (k <= 9)) begin errs++; $display("FAIL emit_dout[%0d] got=%b exp=%b", k, dout, k <= 9); end
      checks++; if (done !== (k == 9)) begin errs++; $display("FAIL emit_done[%0d] got=%b exp=%b", k, done, k == 9); end
    end
    checks++; if (pulses != 9) begin errs++; $display("FAIL emit_pulses got=%0d exp=9", pulses); end
    checks++; if (level !== 4'd0) begin errs++; $display("FAIL emit_level got=%0d exp=0", level); end
  endtask
  task automatic test_overflow();
    tick(1, 0, 0, '0);
    repeat (3) tick(0, 1, 0, 4'b1111);
    tick(0, 1, 0, 4'b0011);
    checks++; if (level !== 4'd14) begin errs++; $display("FAIL ovf_pre got=%0d exp=14", level); end
    tick(0, 1, 0, 4'b1111);
`ifdef UNARY_ADD_N_SAT_EN
    checks++; if (level !== 4'd15) begin errs++; $display("FAIL ovf_level got=%0d exp=15", level); end
`else
    checks++; if (level !== 4'd2) begin errs++; $display("FAIL ovf_level got=%0d exp=2", level); end
`endif
    checks++; if (C !== 1'b1) begin errs++; $display("FAIL ovf_C got=%b exp=1", C); end
    tick(0, 1, 0, 4'b0001);
    checks++; if (level !== 4'(m_cnt)) begin errs++; $display("FAIL ovf2_level got=%0d exp=%0d", level, m_cnt); end
    checks++; if (C !== m_c) begin errs++; $display("FAIL ovf2_C got=%b exp=%b", C, m_c); end
  endtask
  task automatic test_enable();
    tick(1, 0, 0, '0);
    tick(0, 1, 0, 4'b1111);
    tick(0, 1, 0, 4'b0100);
    repeat (2) tick(0, 1, 1, '0);
    checks++; if (level !== 4'd3) begin errs++; $display("FAIL en_pre got=%0d exp=3", level); end
    for (int k = 0; k < 3; k++) begin
      tick(0, 0, 1, 4'($urandom));
      checks++; if (dout !== 1'b0 || level !== 4'd3) begin errs++; $display("FAIL en_hold dout=%b level=%0d exp dout=0 level=3", dout, level); end
    end
    for (int k = 1; k <= 3; k++) begin
      tick(0, 1, 1, '0);
      checks++; if (dout !== 1'b1 || done !== (k == 3)) begin errs++; $display("FAIL en_resume[%0d] dout=%b done=%b exp dout=1 done=%b", k, dout, done, k == 3); end
    end
  endtask
  task automatic test_phase_switch();
    int pulses = 0;
    tick(1, 0, 0, '0);
    tick(0, 1, 0, 4'b0111);
    tick(0, 1, 0, 4'b0011);
    repeat (2) tick(0, 1, 1, '0);
    tick(0, 1, 0, 4'b0011);
    checks++; if (level !== 4'd5) begin errs++; $display("FAIL sw_level got=%0d exp=5", level); end
    repeat (7) begin
      tick(0, 1, 1, '0);
      pulses += dout;
    end
    checks++; if (pulses != 5) begin errs++; $display("FAIL sw_pulses got=%0d exp=5", pulses); end
  endtask
  task automatic test_rst_mid();
    int pulses = 0;
    tick(1, 0, 0, '0);
    repeat (2) tick(0, 1, 0, 4'b1100);
    repeat (3) tick(0, 1, 1, '0);
    tick(1, 1, 1, '0);
    checks++; if (level !== 4'd0 || dout !== 1'b0 || done !== 1'b0) begin errs++; $display("FAIL rst_mid level=%0d dout=%b done=%b exp 0/0/0", level, dout, done); end
    repeat (4) begin
      tick(0, 1, 1, '0);
      pulses += dout;
    end
    checks++; if (pulses != 0) begin errs++; $display("FAIL rst_mid_pulses got=%0d exp=0", pulses); end
  endtask
  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      tick($urandom_range(0, 40) == 0, $urandom_range(0, 5) != 0, $urandom_range(0, 2) == 0, 4'($urandom));
      checks++; if (level !== 4'(m_cnt) || dout !== m_dout || C !== m_c || done !== m_done) begin
        errs++;
        $display("FAIL rand[%0d] level=%0d dout=%b C=%b done=%b exp level=%0d dout=%b C=%b done=%b", k, level, dout, C, done, m_cnt, m_dout, m_c, m_done);
      end
    end
  endtask
  initial begin
    test_reset();
    test_accum_emit();
    test_overflow();
    test_enable();
    test_phase_switch();
    test_rst_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
